// File: rtl/id_ex_stage_reg_pkg.sv
// Shared widths, control-word bit positions and the NOP control word
// for the ID/EX pipeline register.
// Optional feature macro used by this slice: ID_EX_WB_BYPASS_EN.
package riscv_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int PC_W   = 32;
    localparam int CTRL_W = 12;
    localparam int CNT_W  = 16;

    // Bit positions inside the decoded control word
    localparam int REG_WRITE  = 0;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 2;
    localparam int ALU_SRC    = 3;
    localparam int MEM_TO_REG = 4;
    localparam int BRANCH     = 5;
    localparam int JUMP       = 6;
    localparam int ALU_OP_LSB = 7;
    localparam int ALU_OP_MSB = 10;
    localparam int CSR_ACCESS = 11;

    // All-zero control word: no register write, no memory access
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: decode-side fields, the WB write port seen by the register
// file, and the registered EX-side copies.
// master = upstream driver (decode/WB), slave = the pipeline register.
interface id_ex_stage_reg_if
    import riscv_pipe_pkg::*;
#(
    parameter int data_width = DATA_W,
    parameter int reg_width  = REG_W,
    parameter int pc_width   = PC_W,
    parameter int ctrl_width = CTRL_W
) ();

    logic                  stall;
    logic                  flush;
    logic                  id_valid;
    logic [pc_width-1:0]   id_pc;
    logic [reg_width-1:0]  id_rs1_addr;
    logic [reg_width-1:0]  id_rs2_addr;
    logic [reg_width-1:0]  id_rd_addr;
    logic [data_width-1:0] id_rs1_data;
    logic [data_width-1:0] id_rs2_data;
    logic [data_width-1:0] id_imm;
    logic [ctrl_width-1:0] id_ctrl;

    logic                  wb_write_enable;
    logic [reg_width-1:0]  wb_write_addr;
    logic [data_width-1:0] wb_write_data;

    logic                  ex_valid;
    logic [pc_width-1:0]   ex_pc;
    logic [reg_width-1:0]  ex_rs1_addr;
    logic [reg_width-1:0]  ex_rs2_addr;
    logic [reg_width-1:0]  ex_rd_addr;
    logic [data_width-1:0] ex_rs1_data;
    logic [data_width-1:0] ex_rs2_data;
    logic [data_width-1:0] ex_imm;
    logic [ctrl_width-1:0] ex_ctrl;

    modport master (
        output stall, flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_ctrl,
               wb_write_enable, wb_write_addr, wb_write_data,
        input  ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl
    );

    modport slave (
        input  stall, flush, id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr,
               id_rs1_data, id_rs2_data, id_imm, id_ctrl,
               wb_write_enable, wb_write_addr, wb_write_data,
        output ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_ctrl
    );

endinterface

// File: rtl/id_ex_stage_reg_bypass_mux.sv
// WB->ID operand bypass select: forwards the WB write data when the WB write
// targets the operand's register, never for x0.
// Only built when ID_EX_WB_BYPASS_EN is defined.
`ifdef ID_EX_WB_BYPASS_EN
module pipe_bypass_mux
    import riscv_pipe_pkg::*;
#(
    parameter int data_width = DATA_W,
    parameter int reg_width  = REG_W
) (
    input  logic                  write_enable,
    input  logic [reg_width-1:0]  write_addr,
    input  logic [data_width-1:0] write_data,
    input  logic [reg_width-1:0]  read_addr,
    input  logic [data_width-1:0] read_data,
    output logic [data_width-1:0] data
);

    logic hit;

    assign hit  = write_enable && (write_addr == read_addr) && (read_addr != '0);
    assign data = hit ? write_data : read_data;

endmodule
`endif

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall (hold), flush (bubble) and saturating
// stall/flush performance counters. Priority per edge: flush > stall > load.
// Macro ID_EX_WB_BYPASS_EN adds WB->ID forwarding on load and refreshes held
// operands from WB while stalled.
module id_ex_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int data_width = DATA_W,
    parameter int reg_width  = REG_W,
    parameter int pc_width   = PC_W,
    parameter int ctrl_width = CTRL_W,
    parameter int cnt_width  = CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    id_ex_stage_reg_if.slave     bus,
    input  logic                 perf_clear,
    output logic [cnt_width-1:0] perf_stall_cnt,
    output logic [cnt_width-1:0] perf_flush_cnt
);

    // Operand sources: the id_* value on load, the held value while stalled
    logic [data_width-1:0] rs1_next;
    logic [data_width-1:0] rs2_next;

`ifdef ID_EX_WB_BYPASS_EN
    // One mux per operand; while stalled it watches the held address so a
    // WB write landing during the stall is not lost.
    pipe_bypass_mux #(.data_width(data_width), .reg_width(reg_width)) u_rs1_bypass (
        .write_enable (bus.wb_write_enable),
        .write_addr   (bus.wb_write_addr),
        .write_data   (bus.wb_write_data),
        .read_addr    (bus.stall ? bus.ex_rs1_addr : bus.id_rs1_addr),
        .read_data    (bus.stall ? bus.ex_rs1_data : bus.id_rs1_data),
        .data         (rs1_next)
    );

    pipe_bypass_mux #(.data_width(data_width), .reg_width(reg_width)) u_rs2_bypass (
        .write_enable (bus.wb_write_enable),
        .write_addr   (bus.wb_write_addr),
        .write_data   (bus.wb_write_data),
        .read_addr    (bus.stall ? bus.ex_rs2_addr : bus.id_rs2_addr),
        .read_data    (bus.stall ? bus.ex_rs2_data : bus.id_rs2_data),
        .data         (rs2_next)
    );
`else
    logic unused_wb;

    assign rs1_next  = bus.stall ? bus.ex_rs1_data : bus.id_rs1_data;
    assign rs2_next  = bus.stall ? bus.ex_rs2_data : bus.id_rs2_data;
    assign unused_wb = ^{bus.wb_write_enable, bus.wb_write_addr, bus.wb_write_data};
`endif

    // Pipeline register: flush loads a bubble, stall holds, otherwise capture ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc       <= '0;
            bus.ex_rs1_addr <= '0;
            bus.ex_rs2_addr <= '0;
            bus.ex_rd_addr  <= '0;
            bus.ex_rs1_data <= '0;
            bus.ex_rs2_data <= '0;
            bus.ex_imm      <= '0;
            bus.ex_ctrl     <= ctrl_width'(CTRL_NOP);
        end else if (bus.flush) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc       <= '0;
            bus.ex_rs1_addr <= '0;
            bus.ex_rs2_addr <= '0;
            bus.ex_rd_addr  <= '0;
            bus.ex_rs1_data <= '0;
            bus.ex_rs2_data <= '0;
            bus.ex_imm      <= '0;
            bus.ex_ctrl     <= ctrl_width'(CTRL_NOP);
        end else if (bus.stall) begin
            bus.ex_rs1_data <= rs1_next;
            bus.ex_rs2_data <= rs2_next;
        end else begin
            bus.ex_valid    <= bus.id_valid;
            bus.ex_pc       <= bus.id_pc;
            bus.ex_rs1_addr <= bus.id_rs1_addr;
            bus.ex_rs2_addr <= bus.id_rs2_addr;
            bus.ex_rd_addr  <= bus.id_rd_addr;
            bus.ex_rs1_data <= rs1_next;
            bus.ex_rs2_data <= rs2_next;
            bus.ex_imm      <= bus.id_imm;
            bus.ex_ctrl     <= bus.id_valid ? bus.id_ctrl : ctrl_width'(CTRL_NOP);
        end
    end

    // Saturating perf counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (perf_clear) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (bus.flush && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
            if (bus.stall && !bus.flush && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Testbench for id_ex_stage_reg: a reference model pushes the expected EX
// state per edge into a queue; each test task pops and compares inline.
// A second instance with 4-bit counters mirrors the stimulus for saturation.
module tb_id_ex_stage_reg;
    import riscv_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic perf_clear;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int tests  = 0;
    int failed = 0;

    id_ex_stage_reg_if bus ();
    id_ex_stage_reg_if bus4 ();

    id_ex_stage_reg u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .perf_clear(perf_clear),
        .perf_stall_cnt(stall_cnt), .perf_flush_cnt(flush_cnt)
    );

    id_ex_stage_reg #(.cnt_width(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .perf_clear(perf_clear),
        .perf_stall_cnt(stall_cnt4), .perf_flush_cnt(flush_cnt4)
    );

    assign bus4.stall           = bus.stall;
    assign bus4.flush           = bus.flush;
    assign bus4.id_valid        = bus.id_valid;
    assign bus4.id_pc           = bus.id_pc;
    assign bus4.id_rs1_addr     = bus.id_rs1_addr;
    assign bus4.id_rs2_addr     = bus.id_rs2_addr;
    assign bus4.id_rd_addr      = bus.id_rd_addr;
    assign bus4.id_rs1_data     = bus.id_rs1_data;
    assign bus4.id_rs2_data     = bus.id_rs2_data;
    assign bus4.id_imm          = bus.id_imm;
    assign bus4.id_ctrl         = bus.id_ctrl;
    assign bus4.wb_write_enable = bus.wb_write_enable;
    assign bus4.wb_write_addr   = bus.wb_write_addr;
    assign bus4.wb_write_data   = bus.wb_write_data;

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1a, rs2a, rda;
        logic [31:0] rs1d, rs2d, imm;
        logic [11:0] ctrl;
        logic [15:0] scnt, fcnt;
        logic [3:0]  scnt4, fcnt4;
    } snap_t;

    snap_t m;
    snap_t sb[$];

    function automatic snap_t dut_snap();
        snap_t s;
        s.valid = bus.ex_valid;     s.pc   = bus.ex_pc;
        s.rs1a  = bus.ex_rs1_addr;  s.rs2a = bus.ex_rs2_addr; s.rda = bus.ex_rd_addr;
        s.rs1d  = bus.ex_rs1_data;  s.rs2d = bus.ex_rs2_data; s.imm = bus.ex_imm;
        s.ctrl  = bus.ex_ctrl;
        s.scnt  = stall_cnt;        s.fcnt  = flush_cnt;
        s.scnt4 = stall_cnt4;       s.fcnt4 = flush_cnt4;
        return s;
    endfunction

    // Value a register read should deliver given the current WB write
    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] d);
`ifdef ID_EX_WB_BYPASS_EN
        if (bus.wb_write_enable && bus.wb_write_addr == a && a != 5'd0)
            return bus.wb_write_data;
`endif
        return d;
    endfunction

    // Compute the expected post-edge state, queue it, then cross the edge
    task automatic advance();
        snap_t n = m;
        if (bus.flush) begin
            n.valid = 1'b0; n.pc = '0; n.rs1a = '0; n.rs2a = '0; n.rda = '0;
            n.rs1d = '0; n.rs2d = '0; n.imm = '0; n.ctrl = '0;
        end else if (bus.stall) begin
            n.rs1d = fwd(m.rs1a, m.rs1d);
            n.rs2d = fwd(m.rs2a, m.rs2d);
        end else begin
            n.valid = bus.id_valid;
            n.pc    = bus.id_pc;
            n.rs1a  = bus.id_rs1_addr;
            n.rs2a  = bus.id_rs2_addr;
            n.rda   = bus.id_rd_addr;
            n.rs1d  = fwd(bus.id_rs1_addr, bus.id_rs1_data);
            n.rs2d  = fwd(bus.id_rs2_addr, bus.id_rs2_data);
            n.imm   = bus.id_imm;
            n.ctrl  = bus.id_valid ? bus.id_ctrl : 12'h000;
        end
        if (perf_clear) begin
            n.scnt = '0; n.fcnt = '0; n.scnt4 = '0; n.fcnt4 = '0;
        end else if (bus.flush) begin
            if (m.fcnt  != 16'hFFFF) n.fcnt  = m.fcnt + 16'd1;
            if (m.fcnt4 != 4'hF)     n.fcnt4 = m.fcnt4 + 4'd1;
        end else if (bus.stall) begin
            if (m.scnt  != 16'hFFFF) n.scnt  = m.scnt + 16'd1;
            if (m.scnt4 != 4'hF)     n.scnt4 = m.scnt4 + 4'd1;
        end
        m = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] r1,
                            input logic [31:0] d1, input logic [4:0] r2, input logic [31:0] d2,
                            input logic [4:0] rd, input logic [31:0] imm, input logic [11:0] ctrl);
        bus.id_valid = v;     bus.id_pc = pc;
        bus.id_rs1_addr = r1; bus.id_rs1_data = d1;
        bus.id_rs2_addr = r2; bus.id_rs2_data = d2;
        bus.id_rd_addr = rd;  bus.id_imm = imm; bus.id_ctrl = ctrl;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] a, input logic [31:0] d);
        bus.wb_write_enable = we; bus.wb_write_addr = a; bus.wb_write_data = d;
    endtask

    task automatic test_reset();
        snap_t z = '0;
        rst_n = 1'b0; perf_clear = 1'b0;
        bus.stall = 1'b0; bus.flush = 1'b0;
        drive_id(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 12'h0);
        drive_wb(1'b0, 5'd0, 32'h0);
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (dut_snap() !== z) begin
            failed++;
            $display("FAIL reset_state got=%h want=%h", dut_snap(), z);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        snap_t e;
        drive_id(1'b1, 32'h100, 5'd3, 32'hDEADBEEF, 5'd4, 32'h12345678, 5'd9, 32'hFFFF_FFF0, 12'h0A5);
        advance();
        e = sb.pop_front();
        tests++;
        if (dut_snap() !== e) begin failed++; $display("FAIL load_state got=%h want=%h", dut_snap(), e); end
        tests++;
        if (bus.ex_pc !== 32'h100) begin failed++; $display("FAIL load_pc got=%h want=100", bus.ex_pc); end
        tests++;
        if (bus.ex_rs1_data !== 32'hDEADBEEF) begin failed++; $display("FAIL load_rs1 got=%h want=deadbeef", bus.ex_rs1_data); end
        tests++;
        if (bus.ex_ctrl !== 12'h0A5 || bus.ex_valid !== 1'b1) begin
            failed++; $display("FAIL load_ctrl_valid got=%h/%b want=0a5/1", bus.ex_ctrl, bus.ex_valid);
        end
    endtask

    task automatic test_invalid_load();
        snap_t e;
        drive_id(1'b0, 32'h104, 5'd1, 32'h11, 5'd2, 32'h22, 5'd6, 32'h4, 12'hFFF);
        advance();
        e = sb.pop_front();
        tests++;
        if (dut_snap() !== e) begin failed++; $display("FAIL invalid_state got=%h want=%h", dut_snap(), e); end
        tests++;
        if (bus.ex_ctrl !== 12'h000 || bus.ex_valid !== 1'b0 || bus.ex_pc !== 32'h104) begin
            failed++; $display("FAIL invalid_fields got=%h/%b/%h want=000/0/104", bus.ex_ctrl, bus.ex_valid, bus.ex_pc);
        end
    endtask

    task automatic test_stall_flush();
        snap_t e;
        drive_id(1'b1, 32'h200, 5'd8, 32'hCAFE0001, 5'd9, 32'hCAFE0002, 5'd10, 32'h8, 12'h3C1);
        advance();
        e = sb.pop_front();
        tests++;
        if (dut_snap() !== e) begin failed++; $display("FAIL stall_preload got=%h want=%h", dut_snap(), e); end
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 32'h300 + 32'(i * 4), 5'(11 + i), $urandom, 5'(20 + i), $urandom, 5'd1, $urandom, 12'h7FF);
            advance();
            e = sb.pop_front();
            tests++;
            if (dut_snap() !== e) begin failed++; $display("FAIL stall_hold[%0d] got=%h want=%h", i, dut_snap(), e); end
        end
        tests++;
        if (bus.ex_pc !== 32'h200 || bus.ex_rs1_data !== 32'hCAFE0001 || stall_cnt !== 16'd3) begin
            failed++; $display("FAIL stall_summary got pc=%h rs1=%h scnt=%0d want pc=200 rs1=cafe0001 scnt=3",
                               bus.ex_pc, bus.ex_rs1_data, stall_cnt);
        end
        bus.flush = 1'b1;
        advance();
        e = sb.pop_front();
        tests++;
        if (dut_snap() !== e) begin failed++; $display("FAIL flush_state got=%h want=%h", dut_snap(), e); end
        tests++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 12'h0 || flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
            failed++; $display("FAIL flush_stall got v=%b c=%h f=%0d s=%0d want v=0 c=0 f=1 s=3",
                               bus.ex_valid, bus.ex_ctrl, flush_cnt, stall_cnt);
        end
        bus.flush = 1'b0; bus.stall = 1'b0;
    endtask

    task automatic test_bypass();
        snap_t e;
        logic [31:0] want;
`ifdef ID_EX_WB_BYPASS_EN
        want = 32'h55;
`else
        want = 32'h1;
`endif
        drive_id(1'b1, 32'h400, 5'd5, 32'h1, 5'd6, 32'h2, 5'd7, 32'h0, 12'h001);
        drive_wb(1'b1, 5'd5, 32'h55);
        advance();
        e = sb.pop_front();
        tests++;
        if (dut_snap() !== e) begin failed++; $display("FAIL bypass_state got=%h want=%h", dut_snap(), e); end
        tests++;
        if (bus.ex_rs1_data !== want) begin failed++; $display("FAIL bypass_x5 got=%h want=%h", bus.ex_rs1_data, want); end
        drive_id(1'b1, 32'h404, 5'd0, 32'h1, 5'd6, 32'h2, 5'd7, 32'h0, 12'h001);
        drive_wb(1'b1, 5'd0, 32'h55);
        advance();
        e = sb.pop_front();
        tests++;
        if (bus.ex_rs1_data !== 32'h1 || dut_snap() !== e) begin
            failed++; $display("FAIL bypass_x0 got=%h want=1", bus.ex_rs1_data);
        end
        drive_wb(1'b0, 5'd0, 32'h0);
    endtask

    task automatic test_stall_bypass();
        snap_t e;
        logic [31:0] want;
`ifdef ID_EX_WB_BYPASS_EN
        want = 32'h77;
`else
        want = 32'h10;
`endif
        drive_id(1'b1, 32'h500, 5'd2, 32'h20, 5'd7, 32'h10, 5'd3, 32'h0, 12'h011);
        advance();
        void'(sb.pop_front());
        bus.stall = 1'b1;
        drive_id(1'b1, 32'h504, 5'd7, 32'h99, 5'd1, 32'h98, 5'd4, 32'h0, 12'h011);
        drive_wb(1'b1, 5'd7, 32'h77);
        advance();
        e = sb.pop_front();
        tests++;
        if (dut_snap() !== e) begin failed++; $display("FAIL stall_bypass_state got=%h want=%h", dut_snap(), e); end
        tests++;
        if (bus.ex_rs2_data !== want || bus.ex_rs1_data !== 32'h20) begin
            failed++; $display("FAIL stall_bypass_x7 got rs2=%h rs1=%h want rs2=%h rs1=20", bus.ex_rs2_data, bus.ex_rs1_data, want);
        end
        drive_wb(1'b0, 5'd0, 32'h0);
        bus.stall = 1'b0;
    endtask

    task automatic test_reset_mid();
        snap_t e;
        snap_t z = '0;
        drive_id(1'b1, 32'h600, 5'd1, 32'hA1, 5'd2, 32'hA2, 5'd3, 32'hA3, 12'h0F0);
        advance();
        void'(sb.pop_front());
        bus.stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (dut_snap() !== z) begin failed++; $display("FAIL reset_mid got=%h want=%h", dut_snap(), z); end
        m = '0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.stall = 1'b0;
        drive_id(1'b1, 32'h700, 5'd4, 32'hB4, 5'd5, 32'hB5, 5'd6, 32'hB6, 12'h00F);
        advance();
        e = sb.pop_front();
        tests++;
        if (dut_snap() !== e || bus.ex_pc !== 32'h700) begin
            failed++; $display("FAIL reset_then_load got=%h want=%h", dut_snap(), e);
        end
    endtask

    task automatic test_saturation();
        snap_t e;
        perf_clear = 1'b1;
        advance();
        void'(sb.pop_front());
        perf_clear = 1'b0;
        bus.stall = 1'b1;
        repeat (20) begin
            advance();
            void'(sb.pop_front());
        end
        tests++;
        if (stall_cnt4 !== 4'hF || stall_cnt !== 16'd20) begin
            failed++; $display("FAIL saturate got cnt4=%h cnt16=%0d want cnt4=f cnt16=20", stall_cnt4, stall_cnt);
        end
        perf_clear = 1'b1;
        advance();
        e = sb.pop_front();
        tests++;
        if (stall_cnt4 !== 4'h0 || stall_cnt !== 16'd0 || dut_snap() !== e) begin
            failed++; $display("FAIL clear_with_stall got cnt4=%h cnt16=%0d want 0/0", stall_cnt4, stall_cnt);
        end
        perf_clear = 1'b0;
        bus.stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        snap_t e;
        int errs = 0;
        for (int i = 0; i < 40; i++) begin
            bus.stall  = ($urandom_range(0, 3) == 0);
            bus.flush  = ($urandom_range(0, 5) == 0);
            perf_clear = ($urandom_range(0, 15) == 0);
            drive_id(1'($urandom), $urandom, 5'($urandom_range(0, 7)), $urandom,
                     5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)), $urandom, 12'($urandom));
            drive_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            advance();
            e = sb.pop_front();
            tests++;
            if (dut_snap() !== e) begin
                failed++; errs++;
                if (errs < 5) $display("FAIL b2b[%0d] got=%h want=%h", i, dut_snap(), e);
            end
        end
        bus.stall = 1'b0; bus.flush = 1'b0; perf_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_invalid_load();
        test_stall_flush();
        test_bypass();
        test_stall_bypass();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
